// File: rtl/shift_reg_univ_pkg.sv
// Shared types for the universal shift register: mode encodings, serialiser FSM states
// and the bit-counter width helper.
package shift_reg_univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_ASHR  = 3'b110,
    MODE_HOLD2 = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_univ_ctrl.sv
// Frame serialiser control: IDLE/SHIFT FSM and bit counter; flags an accepted start,
// holds busy for WIDTH cycles and pulses done on the edge performing the last shift.
module shift_reg_univ_ctrl
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_start_acc,
  output logic o_busy,
  output logic o_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last)  w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state == ST_SHIFT);
    o_start_acc = (r_state == ST_IDLE) && i_start;
    o_done      = r_done;
  end

  // done is registered so it appears in the cycle after the final shift, with busy low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_SHIFT) && w_last;
      if (o_start_acc)               r_cnt <= '0;
      else if (r_state == ST_SHIFT)  r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold/shift/load/rotate/arith-shift) with an optional frame
// serialiser compiled in by SHIFT_REG_UNIV_FRAME_EN.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_mode;
  logic             w_start_acc;
  logic             w_busy;
  logic             w_done;

`ifdef SHIFT_REG_UNIV_FRAME_EN
  shift_reg_univ_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .o_start_acc (w_start_acc),
    .o_busy      (w_busy),
    .o_done      (w_done)
  );
`else
  logic w_unused_start;
  assign w_unused_start = start;
  assign w_start_acc    = 1'b0;
  assign w_busy         = 1'b0;
  assign w_done         = 1'b0;
`endif

  always_comb begin
    w_q_mode = r_q;
    case (mode_e'(mode))
      MODE_SHR:  w_q_mode = {sin, r_q[WIDTH-1:1]};
      MODE_SHL:  w_q_mode = {r_q[WIDTH-2:0], sin};
      MODE_LOAD: w_q_mode = din;
      MODE_ROTR: w_q_mode = {r_q[0], r_q[WIDTH-1:1]};
      MODE_ROTL: w_q_mode = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      MODE_ASHR: w_q_mode = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      default:   w_q_mode = r_q;
    endcase
  end

  // Frame activity owns the register; mode only acts when idle and no start is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_q <= '0;
    else if (w_start_acc) r_q <= din;
    else if (w_busy)      r_q <= {sin, r_q[WIDTH-1:1]};
    else                  r_q <= w_q_mode;
  end

  assign q    = r_q;
  assign so   = r_q[0];
  assign busy = w_busy;
  assign done = w_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8); frame tests run when
// SHIFT_REG_UNIV_FRAME_EN is defined, the disabled-feature test otherwise.
module tb_shift_reg_univ;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       sin;
  logic [7:0] din;
  logic       start;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_so[$];

  shift_reg_univ #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .mode  (mode),
    .sin   (sin),
    .din   (din),
    .start (start),
    .q     (q),
    .so    (so),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [2:0] m,
                                             input logic s, input logic [7:0] d);
    case (m)
      3'b001:  return {s, cur[7:1]};
      3'b010:  return {cur[6:0], s};
      3'b011:  return d;
      3'b100:  return {cur[0], cur[7:1]};
      3'b101:  return {cur[6:0], cur[7]};
      3'b110:  return {cur[7], cur[7:1]};
      default: return cur;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; mode = 3'b011; sin = 1'b1; din = 8'hFF; start = 1'b0;
    tick; tick;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h want=00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (so !== 1'b0) begin errors++; $display("FAIL reset_so got=%b want=0", so); end
    mode = 3'b000; rst_n = 1'b1;
  endtask

  task automatic test_shift_modes;
    logic [7:0] e;
    logic [2:0] modes[5] = '{3'b011, 3'b001, 3'b010, 3'b000, 3'b111};
    logic       sins[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_q.push_back(8'hA5); exp_q.push_back(8'hD2); exp_q.push_back(8'hA4);
    exp_q.push_back(8'hA4); exp_q.push_back(8'hA4);
    din = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      mode = modes[i]; sin = sins[i];
      tick;
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin errors++; $display("FAIL shift_mode%0d got=%h want=%h", i, q, e); end
    end
  endtask

  task automatic test_rotate_modes;
    logic [7:0] e;
    logic [2:0] modes[7] = '{3'b011, 3'b100, 3'b101, 3'b101, 3'b011, 3'b110, 3'b110};
    logic [7:0] dins[7]  = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
    exp_q.push_back(8'h81); exp_q.push_back(8'hC0); exp_q.push_back(8'h81);
    exp_q.push_back(8'h03); exp_q.push_back(8'h80); exp_q.push_back(8'hC0);
    exp_q.push_back(8'hE0);
    sin = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mode = modes[i]; din = dins[i];
      tick;
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin errors++; $display("FAIL rotate_step%0d got=%h want=%h", i, q, e); end
    end
  endtask

  task automatic test_random_modes;
    logic [7:0] m;
    logic [7:0] e;
    mode = 3'b011; din = 8'h5C; tick;
    m = 8'h5C;
    for (int i = 0; i < 24; i++) begin
      mode = 3'($urandom_range(0, 7));
      sin  = 1'($urandom_range(0, 1));
      din  = 8'($urandom_range(0, 255));
      m = model_next(m, mode, sin, din);
      exp_q.push_back(m);
      tick;
      e = exp_q.pop_front();
      checks++;
      if (q !== e) begin errors++; $display("FAIL random_mode%0d mode=%b got=%h want=%h", i, mode, q, e); end
    end
    mode = 3'b000;
  endtask

`ifdef SHIFT_REG_UNIV_FRAME_EN
  task automatic test_frame;
    logic b;
    mode = 3'b000; sin = 1'b0; din = 8'h3C; start = 1'b1;
    for (int i = 0; i < 8; i++) exp_so.push_back(din[i]);
    tick;
    start = 1'b0; din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      b = exp_so.pop_front();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || so !== b) begin
        errors++;
        $display("FAIL frame_cycle%0d busy=%b done=%b so=%b want busy=1 done=0 so=%b", i, busy, done, so, b);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h00) begin
      errors++; $display("FAIL frame_done busy=%b done=%b q=%h want 0 1 00", busy, done, q);
    end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_back_to_back;
    logic b;
    mode = 3'b000; sin = 1'b0; din = 8'hA5; start = 1'b1;
    for (int i = 0; i < 8; i++) exp_so.push_back(din[i]);
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = exp_so.pop_front();
      checks++;
      if (busy !== 1'b1 || so !== b) begin
        errors++; $display("FAIL busy_ignore_cycle%0d busy=%b so=%b want busy=1 so=%b", i, busy, so, b);
      end
      if (i == 2) begin start = 1'b1; mode = 3'b011; din = 8'hFF; end
      else        begin start = 1'b0; mode = 3'b000; end
      tick;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first_done done=%b busy=%b want 1 0", done, busy);
    end
    din = 8'h0F; start = 1'b1;
    for (int i = 0; i < 8; i++) exp_so.push_back(din[i]);
    tick;
    start = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = exp_so.pop_front();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || so !== b) begin
        errors++;
        $display("FAIL b2b_second_cycle%0d busy=%b done=%b so=%b want 1 0 %b", i, busy, done, so, b);
      end
      tick;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b want=1", done); end
    tick;
  endtask

  task automatic test_async_reset;
    mode = 3'b000; sin = 1'b1; din = 8'hFF; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset q=%h busy=%b done=%b want 00 0 0", q, busy, done);
    end
    tick;
    rst_n = 1'b1; mode = 3'b000;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_no_done cycle%0d done=%b busy=%b want 0 0", i, done, busy);
      end
      tick;
    end
    mode = 3'b011; din = 8'h66;
    tick;
    checks++; if (q !== 8'h66) begin errors++; $display("FAIL resume_load got=%h want=66", q); end
    mode = 3'b000;
  endtask
`else
  task automatic test_no_frame;
    mode = 3'b011; din = 8'h5A; start = 1'b1;
    tick;
    checks++;
    if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL noframe_load q=%h busy=%b done=%b want 5a 0 0", q, busy, done);
    end
    mode = 3'b001; sin = 1'b0;
    tick;
    checks++;
    if (q !== 8'h2D || busy !== 1'b0) begin
      errors++; $display("FAIL noframe_shr q=%h busy=%b want 2d 0", q, busy);
    end
    start = 1'b0; mode = 3'b000;
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL noframe_done got=%b want=0", done); end
  endtask
`endif

  initial begin
    test_reset;
    test_shift_modes;
    test_rotate_modes;
    test_random_modes;
`ifdef SHIFT_REG_UNIV_FRAME_EN
    test_frame;
    test_back_to_back;
    test_async_reset;
`else
    test_no_frame;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: mode  input  3  operation select when idle (see REQ-011).
REQ-005 SHALL have port: sin  input  1  serial input bit.
REQ-006 SHALL have port: din  input  WIDTH  parallel load / frame data.
REQ-007 SHALL have port: start  input  1  frame-serialise request, sampled per cycle.
REQ-008 SHALL have port: q  output  WIDTH  register contents.
REQ-009 SHALL have port: so  output  1  serial out, combinationally q[0].
REQ-010 SHALL have ports: busy  output  1  frame in progress; done  output  1  one-cycle frame-complete pulse.

Function
REQ-011 SHALL decode mode when idle: 000 hold; 001 shr (sin->MSB); 010 shl (sin->LSB); 011 load din; 100 rotr; 101 rotl; 110 arithmetic shr (MSB kept); 111 hold.
REQ-012 SHALL apply the selected mode at every rising edge where busy=0 and start is not accepted.
REQ-013 SHALL use FSM states IDLE and SHIFT; IDLE->SHIFT on start=1 in IDLE; SHIFT->IDLE after the last shift.
REQ-014 SHALL, on accepted start: q<=din, busy<=1, bit counter<=0; mode ignored that cycle.
REQ-015 SHALL, each edge in SHIFT: shift right with sin into MSB, counter+1; counter width $clog2(WIDTH).
REQ-016 SHALL leave SHIFT on the edge performing shift number WIDTH: busy<=0, done<=1 for exactly one cycle.
REQ-017 SHALL keep busy high exactly WIDTH cycles, so=din[i] during the i-th busy cycle (i=0 first).
REQ-018 SHALL ignore start and mode while busy=1; start asserted on the done cycle is accepted (back-to-back frames).
REQ-019 SHALL hold done=0 at all times except REQ-016.

Reset
REQ-020 SHALL, while rst=0, force q=0, busy=0, done=0, counter=0, state IDLE, independent of clk.
REQ-021 SHALL abort an in-progress frame on reset with no done pulse.
REQ-022 SHALL resume normal operation at the first rising edge after rst returns to 1.

Configuration
REQ-023 SHALL compile the frame serialiser only when SHIFT_REG_UNIV_FRAME_EN is defined.
REQ-024 SHALL, without SHIFT_REG_UNIV_FRAME_EN, ignore start, tie busy=0 and done=0, and apply mode every edge.

Structure
REQ-025 SHALL place mode encodings and FSM state typedef in package shift_reg_univ_pkg.
REQ-026 SHALL place FSM and bit counter in sub-module shift_reg_univ_ctrl; datapath stays in top.

Verification (WIDTH=8)
REQ-027 SHALL check: load 8'hA5 (mode 011), then mode 001 sin=1 one edge -> q=8'hD2; mode 010 sin=0 -> q=8'hA4.
REQ-028 SHALL check: load 8'h81, mode 100 one edge -> q=8'hC0; mode 101 two edges -> q=8'h03; mode 110 on 8'h80 -> 8'hC0.
REQ-029 SHALL check: start with din=8'h3C, sin=0 -> busy high 8 cycles, so sequence 0,0,1,1,1,1,0,0, then done=1 one cycle, q=8'h00.
REQ-030 SHALL check: start and mode 011 pulsed during busy -> no effect; start on done cycle -> second frame begins, busy stays high.
REQ-031 SHALL check: rst=0 asserted mid-frame between clock edges -> q=0, busy=0 immediately, no done pulse.
REQ-032 SHALL check: build without SHIFT_REG_UNIV_FRAME_EN, start=1 with mode 011, din=8'h5A -> q=8'h5A, busy=0.
